// File: rtl/dm_pkg.sv
// rtl/dm_pkg.sv - shared constants and state encoding for the data-memory arbiter
package dm_pkg;

    localparam logic [31:0] DM_BASE_ADDR = 32'h4700_0000;
    localparam int          DM_WORDS     = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } dm_state_t;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

endpackage

// File: rtl/dm_rr_arb.sv
// rtl/dm_rr_arb.sv - two-input round-robin picker
//
// Ports:
//   req  in  [1:0] request per master
//   ptr  in        master that wins when both request
//   idx  out       index of the winning master
//   any  out       at least one request present
module dm_rr_arb
    import dm_pkg::*;
(
    input  logic [1:0] req,
    input  logic       ptr,
    output logic       idx,
    output logic       any
);

    always_comb begin
        any = |req;
        if (req == 2'b11) begin
            idx = ptr;
        end else if (req[1]) begin
            idx = M1;
        end else begin
            idx = M0;
        end
    end

endmodule

// File: rtl/dm_arbiter.sv
// rtl/dm_arbiter.sv - two-master round-robin sequencer for the single-port data memory
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   mN_req/we/addr/wdata  in       master N request, held until mN_gnt
//   mN_gnt                out      one-cycle accept pulse (during the DM access cycle)
//   mN_rvalid/rdata/err   out      one-cycle response; err flags an out-of-window address
//   dm_a/dm_wd/dm_we      out      DM address, write data, write enable
//   dm_rd                 in       DM read data, combinational from dm_a
module dm_arbiter
    import dm_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DM_BASE_ADDR,
    parameter int          WORDS     = DM_WORDS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic        m1_err,
    output logic [31:0] dm_a,
    output logic [31:0] dm_wd,
    output logic        dm_we,
    input  logic [31:0] dm_rd
);

    // 33-bit bounds so a window touching the top of the address space cannot wrap.
    localparam logic [32:0] WIN_LO = {1'b0, BASE_ADDR};
    localparam logic [32:0] WIN_HI = WIN_LO + 33'(4 * WORDS);

    dm_state_t   state, state_n;
    logic        ptr, ptr_n;
    logic        cmd_idx, cmd_idx_n;
    logic        cmd_we, cmd_we_n;
    logic        cmd_win, cmd_win_n;
    logic [1:0]  gnt_q, gnt_n;
    logic [1:0]  rvalid_q, rvalid_n;
    logic [1:0]  err_q, err_n;
    logic [31:0] rdata0_q, rdata0_n;
    logic [31:0] rdata1_q, rdata1_n;
    logic [31:0] dm_a_q, dm_a_n;
    logic [31:0] dm_wd_q, dm_wd_n;
    logic        dm_we_q, dm_we_n;

    logic        arb_idx;
    logic        arb_any;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        sel_win;

    dm_rr_arb u_rr_arb (
        .req ({m1_req, m0_req}),
        .ptr (ptr),
        .idx (arb_idx),
        .any (arb_any)
    );

    assign sel_we    = (arb_idx == M1) ? m1_we    : m0_we;
    assign sel_addr  = (arb_idx == M1) ? m1_addr  : m0_addr;
    assign sel_wdata = (arb_idx == M1) ? m1_wdata : m0_wdata;
    assign sel_win   = ({1'b0, sel_addr} >= WIN_LO) && ({1'b0, sel_addr} < WIN_HI);

    // All outputs are registered, so each state computes the values that will
    // be visible during the following state.
    always_comb begin
        state_n   = state;
        ptr_n     = ptr;
        cmd_idx_n = cmd_idx;
        cmd_we_n  = cmd_we;
        cmd_win_n = cmd_win;
        dm_a_n    = dm_a_q;
        dm_wd_n   = dm_wd_q;
        dm_we_n   = 1'b0;
        gnt_n     = 2'b00;
        rvalid_n  = 2'b00;
        err_n     = 2'b00;
        rdata0_n  = 32'h0;
        rdata1_n  = 32'h0;
        case (state)
            IDLE: begin
                if (arb_any) begin
                    cmd_idx_n        = arb_idx;
                    cmd_we_n         = sel_we;
                    cmd_win_n        = sel_win;
                    dm_a_n           = {sel_addr[31:2], 2'b00};
                    dm_wd_n          = sel_wdata;
                    dm_we_n          = sel_we & sel_win;
                    gnt_n[arb_idx]   = 1'b1;
                    state_n          = ACCESS;
                end
            end
            ACCESS: begin
                rvalid_n[cmd_idx] = 1'b1;
                err_n[cmd_idx]    = ~cmd_win;
                if (!cmd_we && cmd_win) begin
                    if (cmd_idx == M1) begin
                        rdata1_n = dm_rd;
                    end else begin
                        rdata0_n = dm_rd;
                    end
                end
                // Loser of this round gets priority next time.
                ptr_n   = ~cmd_idx;
                state_n = RESP;
            end
            RESP: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= M0;
            cmd_idx  <= M0;
            cmd_we   <= 1'b0;
            cmd_win  <= 1'b0;
            gnt_q    <= 2'b00;
            rvalid_q <= 2'b00;
            err_q    <= 2'b00;
            rdata0_q <= 32'h0;
            rdata1_q <= 32'h0;
            dm_a_q   <= 32'h0;
            dm_wd_q  <= 32'h0;
            dm_we_q  <= 1'b0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            cmd_idx  <= cmd_idx_n;
            cmd_we   <= cmd_we_n;
            cmd_win  <= cmd_win_n;
            gnt_q    <= gnt_n;
            rvalid_q <= rvalid_n;
            err_q    <= err_n;
            rdata0_q <= rdata0_n;
            rdata1_q <= rdata1_n;
            dm_a_q   <= dm_a_n;
            dm_wd_q  <= dm_wd_n;
            dm_we_q  <= dm_we_n;
        end
    end

    assign m0_gnt    = gnt_q[0];
    assign m1_gnt    = gnt_q[1];
    assign m0_rvalid = rvalid_q[0];
    assign m1_rvalid = rvalid_q[1];
    assign m0_err    = err_q[0];
    assign m1_err    = err_q[1];
    assign m0_rdata  = rdata0_q;
    assign m1_rdata  = rdata1_q;
    assign dm_a      = dm_a_q;
    assign dm_wd     = dm_wd_q;
    assign dm_we     = dm_we_q;

endmodule
